// File: rtl/sd_pattern_gen.sv
// Serial pattern transmitter: shifts a 1..MAX_LEN bit pattern out MSB-first,
// optionally repeating it with a fixed idle gap between passes.
`timescale 1ns/1ps
module sd_pattern_gen #(
  parameter int unsigned MAX_LEN    = 16,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [MAX_LEN-1:0] pat_data,
  input  logic [4:0]         pat_len,
  input  logic [3:0]         repeat_cnt,
  output logic               pattern_out,
  output logic               bit_valid,
  output logic               busy,
  output logic               done
);

  localparam int unsigned     GAP_W    = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [4:0]      MAX_LEN5 = 5'(MAX_LEN);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t             state;
  logic [MAX_LEN-1:0] pat_q;
  logic [MAX_LEN-1:0] shreg;
  logic [4:0]         len_q;
  logic [4:0]         bit_cnt;
  logic [3:0]         pass_cnt;
  logic [GAP_W-1:0]   gap_cnt;

  logic               start_ok_c;
  logic [MAX_LEN-1:0] aligned_c;

  // Pattern left-justified so the first bit to send sits at the MSB.
  assign start_ok_c = start && (pat_len != 5'd0) && (pat_len <= MAX_LEN5);
  assign aligned_c  = pat_data << (MAX_LEN5 - pat_len);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pat_q       <= '0;
      shreg       <= '0;
      len_q       <= '0;
      bit_cnt     <= '0;
      pass_cnt    <= '0;
      gap_cnt     <= '0;
      pattern_out <= 1'b0;
      bit_valid   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_ok_c) begin
            pat_q       <= aligned_c;
            shreg       <= aligned_c << 1;
            len_q       <= pat_len;
            bit_cnt     <= pat_len - 5'd1;
            pass_cnt    <= repeat_cnt;
            gap_cnt     <= '0;
            pattern_out <= aligned_c[MAX_LEN-1];
            bit_valid   <= 1'b1;
            busy        <= 1'b1;
            done        <= 1'b0;
            state       <= SEND;
          end
        end

        SEND: begin
          if (abort) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            pass_cnt    <= '0;
            gap_cnt     <= '0;
            pattern_out <= 1'b0;
            bit_valid   <= 1'b0;
            busy        <= 1'b0;
          end else if (bit_cnt != 5'd0) begin
            pattern_out <= shreg[MAX_LEN-1];
            shreg       <= shreg << 1;
            bit_cnt     <= bit_cnt - 5'd1;
          end else if (pass_cnt != 4'd0) begin
            // Last bit of a pass with more passes pending.
            pass_cnt <= pass_cnt - 4'd1;
            if (GAP_CYCLES > 0) begin
              state       <= GAP;
              gap_cnt     <= GAP_LOAD;
              pattern_out <= 1'b0;
              bit_valid   <= 1'b0;
            end else begin
              pattern_out <= pat_q[MAX_LEN-1];
              shreg       <= pat_q << 1;
              bit_cnt     <= len_q - 5'd1;
              bit_valid   <= 1'b1;
            end
          end else begin
            state       <= IDLE;
            pattern_out <= 1'b0;
            bit_valid   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b1;
          end
        end

        GAP: begin
          if (abort) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            pass_cnt    <= '0;
            gap_cnt     <= '0;
            pattern_out <= 1'b0;
            bit_valid   <= 1'b0;
            busy        <= 1'b0;
          end else if (gap_cnt == '0) begin
            state       <= SEND;
            pattern_out <= pat_q[MAX_LEN-1];
            shreg       <= pat_q << 1;
            bit_cnt     <= len_q - 5'd1;
            bit_valid   <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end

        default: begin
          state       <= IDLE;
          pattern_out <= 1'b0;
          bit_valid   <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sd_pattern_gen.sv
// Scoreboard bench for sd_pattern_gen: per-cycle expected outputs are queued
// as stimulus is driven and compared on the falling edge.
`timescale 1ns/1ps
module tb_sd_pattern_gen;

  localparam int unsigned GAP = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [15:0] pat_data;
  logic [4:0]  pat_len;
  logic [3:0]  repeat_cnt;
  logic        pattern_out;
  logic        bit_valid;
  logic        busy;
  logic        done;

  sd_pattern_gen #(.MAX_LEN(16), .GAP_CYCLES(GAP)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .pat_data   (pat_data),
    .pat_len    (pat_len),
    .repeat_cnt (repeat_cnt),
    .pattern_out(pattern_out),
    .bit_valid  (bit_valid),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [3:0] v;   // {pattern_out, bit_valid, busy, done}
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_bad    = 0;
  logic exp_done = 1'b0;
  int   job_id   = 0;

  int   abort_at    = -1;
  int   start_at    = -1;
  int   rst_at      = -1;
  bit   abort_first = 1'b0;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got {out,valid,busy,done}=%b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      check(mon_e.tag, {pattern_out, bit_valid, busy, done}, mon_e.v);
    end
  end

  // One cycle: queue what the outputs must show now, then advance past the edge.
  task automatic step(input string tag, input logic [3:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input string tag);
    repeat (n) step(tag, {3'b000, exp_done});
  endtask

  task automatic emit(input logic [3:0] e, input string tag, input int k, output bit stop);
    if (k == start_at) begin
      start    = 1'b1;
      pat_data = ~pat_data;
      pat_len  = 5'd2;
    end
    if (k == abort_at) abort = 1'b1;
    if (k == rst_at)   rst   = 1'b1;
    stop = (k == abort_at) || (k == rst_at);
    step(tag, e);
    start = 1'b0;
    abort = 1'b0;
    rst   = 1'b0;
  endtask

  task automatic run_job(input logic [15:0] data, input int len, input int rep);
    int k;
    bit stopped;
    bit s;
    job_id++;
    pat_data   = data;
    pat_len    = 5'(len);
    repeat_cnt = 4'(rep);
    start      = 1'b1;
    abort      = abort_first;
    step($sformatf("j%0d_accept", job_id), {3'b000, exp_done});
    start    = 1'b0;
    abort    = 1'b0;
    exp_done = 1'b0;
    k        = 0;
    stopped  = 1'b0;
    for (int p = 0; p <= rep; p++) begin
      for (int i = len - 1; i >= 0; i--) begin
        if (!stopped) begin
          emit({data[i], 3'b110}, $sformatf("j%0d_p%0d_bit%0d", job_id, p, i), k, s);
          stopped = s;
          k++;
        end
      end
      if (p < rep) begin
        for (int g = 0; g < int'(GAP); g++) begin
          if (!stopped) begin
            emit(4'b0010, $sformatf("j%0d_gap%0d_%0d", job_id, p, g), k, s);
            stopped = s;
            k++;
          end
        end
      end
    end
    if (!stopped) exp_done = 1'b1;
    step($sformatf("j%0d_end", job_id), {3'b000, exp_done});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    pat_data   = '0;
    pat_len    = '0;
    repeat_cnt = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(20, "reset_idle");

    run_job(16'h000E, 4, 0);
    idle(2, "single_done_hold");

    run_job(16'h0005, 3, 2);
    idle(1, "repeat_done_hold");

    run_job(16'h8001, 16, 0);
    idle(1, "len16_done_hold");

    pat_len = 5'd0;
    start   = 1'b1;
    step("len0_start", {3'b000, exp_done});
    start = 1'b0;
    idle(3, "len0_ignored");

    pat_len = 5'd17;
    start   = 1'b1;
    step("len17_start", {3'b000, exp_done});
    start = 1'b0;
    idle(3, "len17_ignored");

    start_at = 1;
    run_job(16'h000E, 4, 0);
    start_at = -1;
    idle(1, "ign_start_hold");

    abort_at = 1;
    run_job(16'h000E, 4, 0);
    abort_at = -1;
    idle(2, "abort_idle");
    run_job(16'h0009, 4, 1);
    idle(1, "post_abort_hold");

    abort_first = 1'b1;
    run_job(16'h0006, 3, 0);
    abort_first = 1'b0;
    idle(1, "start_wins_hold");

    rst_at = 4;
    run_job(16'h0005, 3, 1);
    rst_at = -1;
    idle(1, "rst_gap_idle");
    run_job(16'h0003, 2, 0);
    idle(2, "final_hold");

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
